// File: rtl/sram_pkg.sv
// Shared definitions for the banked SRAM core and its AXI wrapper:
// controller state enum, per-byte parity helper and the wrapper's row address type.
package sram_pkg;

  localparam int SRAM_ADDR_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_row_addr_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_t;

  // Even parity: the stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One SRAM bank: byte-enabled storage, optional per-byte parity (SRAM_BANK_ARRAY_PARITY_EN)
// and a READ_LATENCY-deep read pipe whose last stage is the registered read data.
module sram_bank
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cs_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_WIDTH/8-1:0]  be_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     flip_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     parity_err_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = READ_LATENCY;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NB-1:0]         rd_par;

  // Storage is deliberately not reset; the controller's sweep zeroes it.
  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[addr_i];

`ifdef SRAM_BANK_ARRAY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (cs_i && we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) par_mem[addr_i][b] <= byte_parity(wdata_i[8*b +: 8]) ^ flip_i;
      end
    end
  end

  assign rd_par = par_mem[addr_i];
`else
  localparam bit PAR_EN = 1'b0;
  logic unused_flip;

  assign unused_flip = flip_i;
  assign rd_par      = '0;
`endif

  logic [L-1:0]          vld_d, vld_q;
  logic [DATA_WIDTH-1:0] data_d [L];
  logic [DATA_WIDTH-1:0] data_q [L];
  logic [NB-1:0]         par_d  [L];
  logic [NB-1:0]         par_q  [L];
  logic                  mism;

  // Each stage's incoming valid/data; a stage only loads when its incoming valid is set.
  always_comb begin
    vld_d[0]  = cs_i && !we_i;
    data_d[0] = rd_word;
    par_d[0]  = rd_par;
    for (int i = 1; i < L; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
      par_d[i]  = par_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < L; i++) begin
        data_q[i] <= '0;
        par_q[i]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < L; i++) begin
        if (vld_d[i]) begin
          data_q[i] <= data_d[i];
          par_q[i]  <= par_d[i];
        end
      end
    end
  end

  always_comb begin
    mism = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (byte_parity(data_q[L-1][8*b +: 8]) != par_q[L-1][b]) mism = 1'b1;
    end
  end

  assign rdata_o      = data_q[L-1];
  assign parity_err_o = PAR_EN && vld_q[L-1] && mism;

endmodule

// File: rtl/sram_bank_array.sv
// ROWS x COLS banked SRAM core: post-reset zeroing sweep (INIT -> READY) and bus fan-out.
// Optional per-byte parity is enabled with `define SRAM_BANK_ARRAY_PARITY_EN.
module sram_bank_array
  import sram_pkg::*;
#(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 16,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_BANK_DEPTH      = 1024,
  parameter int SRAM_READ_LATENCY    = 2
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_ni,
  input  logic [SRAM_BANK_ADDR_WIDTH-1:0]                         bank_addr,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]         bank_cs,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]         bank_we,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0] bank_be,
  input  logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]    bank_wdata,
  output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0] bank_rdata,
  input  logic                                                    parity_flip_i,
  output logic                                                    init_done_o,
  output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]         parity_err_o
);

  localparam int NB = SRAM_BANK_DATA_WIDTH / 8;
  localparam int IW = $clog2(SRAM_BANK_DEPTH);

  init_state_t   state_d, state_q;
  logic [IW-1:0] init_cnt_d, init_cnt_q;
  logic          in_init;
  logic [IW-1:0] word_addr;
  logic          unused_addr;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == IW'(SRAM_BANK_DEPTH - 1)) state_d = READY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_done_o = (state_q == READY);
  assign in_init     = (state_q == INIT);
  // During the sweep every bank is forced to a full-word zero write at init_cnt.
  assign word_addr   = in_init ? init_cnt_q : bank_addr[IW-1:0];
  assign unused_addr = ^bank_addr;

  for (genvar r = 0; r < SRAM_BANKS_ROWS; r++) begin : g_row
    for (genvar c = 0; c < SRAM_BANKS_COLS; c++) begin : g_col
      sram_bank #(
        .DATA_WIDTH   (SRAM_BANK_DATA_WIDTH),
        .DEPTH        (SRAM_BANK_DEPTH),
        .READ_LATENCY (SRAM_READ_LATENCY)
      ) u_bank (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cs_i         (in_init || bank_cs[r][c]),
        .we_i         (in_init || bank_we[r][c]),
        .addr_i       (word_addr),
        .be_i         (in_init ? {NB{1'b1}} : bank_be[r][c]),
        .wdata_i      (in_init ? {SRAM_BANK_DATA_WIDTH{1'b0}} : bank_wdata[c]),
        .flip_i       (!in_init && parity_flip_i),
        .rdata_o      (bank_rdata[r][c]),
        .parity_err_o (parity_err_o[r][c])
      );
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && in_init)
      assert (bank_cs == '0) else $warning("bank_cs asserted during INIT sweep; access dropped");
  end

endmodule

// File: tb/tb_sram_bank_array.sv
// Randomized bench for sram_bank_array against a word/byte-level memory model with
// timestamped read results.
module tb_sram_bank_array;
  localparam int ROWS = 2, COLS = 2, AW = 8, DW = 32, DEPTH = 16, LAT = 3, NB = DW / 8;
`ifdef SRAM_BANK_ARRAY_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni;
  logic [AW-1:0] bank_addr;
  logic [ROWS-1:0][COLS-1:0] bank_cs, bank_we, parity_err_o;
  logic [ROWS-1:0][COLS-1:0][NB-1:0] bank_be;
  logic [COLS-1:0][DW-1:0] bank_wdata;
  logic [ROWS-1:0][COLS-1:0][DW-1:0] bank_rdata;
  logic parity_flip_i, init_done_o;

  always #5 clk = ~clk;

  sram_bank_array #(
    .SRAM_BANKS_ROWS(ROWS), .SRAM_BANKS_COLS(COLS), .SRAM_BANK_ADDR_WIDTH(AW),
    .SRAM_BANK_DATA_WIDTH(DW), .SRAM_BANK_DEPTH(DEPTH), .SRAM_READ_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bank_addr(bank_addr), .bank_cs(bank_cs),
    .bank_we(bank_we), .bank_be(bank_be), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .parity_flip_i(parity_flip_i),
    .init_done_o(init_done_o), .parity_err_o(parity_err_o)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain memory contents, corrupted-parity flags, and read results
  // tagged with the edge number at which they must be visible.
  typedef struct { int bank; int due; logic [DW-1:0] data; logic perr; } rd_t;
  logic [DW-1:0] mem_m [ROWS][COLS][DEPTH];
  logic [NB-1:0] bad_m [ROWS][COLS][DEPTH];
  logic [DW-1:0] exp_rd [ROWS][COLS];
  rd_t rq [$];
  int sweep = 0, edge_n = 0, perr00_cnt = 0;

  task automatic model_reset();
    sweep = 0;
    rq.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_rd[r][c] = '0;
        for (int a = 0; a < DEPTH; a++) begin
          mem_m[r][c][a] = '0;
          bad_m[r][c][a] = '0;
        end
      end
  endtask

  task automatic model_edge();
    rd_t e;
    int a;
    if (!rst_ni) return;
    if (sweep < DEPTH) begin
      sweep++;
      return;
    end
    a = int'(bank_addr) % DEPTH;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (bank_cs[r][c]) begin
          if (bank_we[r][c]) begin
            for (int b = 0; b < NB; b++)
              if (bank_be[r][c][b]) begin
                mem_m[r][c][a][8*b +: 8] = bank_wdata[c][8*b +: 8];
                if (PAR) bad_m[r][c][a][b] = parity_flip_i;
              end
          end else begin
            e.bank = r * COLS + c;
            e.due  = edge_n + LAT - 1;
            e.data = mem_m[r][c][a];
            e.perr = PAR && (bad_m[r][c][a] != '0);
            rq.push_back(e);
          end
        end
  endtask

  task automatic compare_all();
    logic [ROWS-1:0][COLS-1:0] exp_perr;
    exp_perr = '0;
    while (rq.size() > 0 && rq[0].due <= edge_n) begin
      exp_rd[rq[0].bank / COLS][rq[0].bank % COLS] = rq[0].data;
      exp_perr[rq[0].bank / COLS][rq[0].bank % COLS] = rq[0].perr;
      void'(rq.pop_front());
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        chk($sformatf("rdata[%0d][%0d]@%0d", r, c, edge_n), bank_rdata[r][c], exp_rd[r][c]);
        chk($sformatf("perr[%0d][%0d]@%0d", r, c, edge_n), parity_err_o[r][c], exp_perr[r][c]);
      end
    chk($sformatf("init_done@%0d", edge_n), init_done_o, sweep >= DEPTH);
    if (parity_err_o[0][0]) perr00_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    bank_cs = '0; bank_we = '0; bank_be = '0; parity_flip_i = 1'b0;
  endtask

  task automatic all_read(input int a);
    bank_cs = '1; bank_we = '0; bank_addr = AW'(a);
  endtask

  initial begin
    rst_ni = 1'b0; bank_addr = '0; bank_wdata = '0;
    idle();
    model_reset();
    #1;
    chk("reset_rdata", bank_rdata, '0);
    chk("reset_init_done", init_done_o, 1'b0);
    chk("reset_perr", parity_err_o, '0);
    repeat (2) cycle();
    rst_ni = 1'b1;

    // Sweep, then every word of every bank reads zero.
    repeat (DEPTH + 1) cycle();
    for (int a = 0; a < DEPTH; a++) begin all_read(a); cycle(); end
    idle();
    repeat (LAT) cycle();

    // Byte-enabled write then read of bank [0][0], addr 5.
    bank_cs[0][0] = 1'b1; bank_we[0][0] = 1'b1; bank_be[0][0] = 4'b0101;
    bank_addr = 8'd5; bank_wdata[0] = 32'hDEADBEEF;
    cycle();
    idle(); bank_cs[0][0] = 1'b1;
    cycle();
    idle();
    repeat (LAT - 2) cycle();
    chk("deadbeef_early", bank_rdata[0][0], 32'h0);
    cycle();
    chk("deadbeef", bank_rdata[0][0], 32'h00AD00EF);

    // Write then read on the next cycle, bank [1][1] addr 3.
    bank_cs[1][1] = 1'b1; bank_we[1][1] = 1'b1; bank_be[1][1] = 4'hF;
    bank_addr = 8'd3; bank_wdata[1] = 32'h1234;
    cycle();
    idle(); bank_cs[1][1] = 1'b1;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
    chk("wr_then_rd", bank_rdata[1][1], 32'h1234);

    // Fill addrs 0..7 everywhere, back-to-back reads, then hold.
    for (int a = 0; a < 8; a++) begin
      bank_cs = '1; bank_we = '1; bank_be = '1; bank_addr = AW'(a);
      for (int c = 0; c < COLS; c++) bank_wdata[c] = $urandom;
      cycle();
    end
    for (int a = 0; a < 8; a++) begin all_read(a); cycle(); end
    idle();
    repeat (LAT + 3) cycle();

    // Random traffic, including upper address bits and parity flips.
    repeat (300) begin
      bank_cs = ROWS * COLS'($urandom); bank_we = ROWS * COLS'($urandom);
      bank_cs = 4'($urandom); bank_we = 4'($urandom);
      bank_be = 16'($urandom); bank_addr = AW'($urandom);
      for (int c = 0; c < COLS; c++) bank_wdata[c] = $urandom;
      parity_flip_i = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle();
    repeat (LAT) cycle();

    // Parity: corrupted write pulses once, clean rewrite does not.
    perr00_cnt = 0;
    bank_cs[0][0] = 1'b1; bank_we[0][0] = 1'b1; bank_be[0][0] = 4'hF;
    bank_addr = 8'd9; bank_wdata[0] = 32'hA5A51234; parity_flip_i = 1'b1;
    cycle();
    idle(); bank_cs[0][0] = 1'b1;
    cycle();
    idle();
    repeat (LAT + 1) cycle();
    chk("perr_flip_pulses", perr00_cnt, PAR ? 1 : 0);
    perr00_cnt = 0;
    bank_cs[0][0] = 1'b1; bank_we[0][0] = 1'b1; bank_be[0][0] = 4'hF;
    cycle();
    idle(); bank_cs[0][0] = 1'b1;
    cycle();
    idle();
    repeat (LAT + 1) cycle();
    chk("perr_clean_pulses", perr00_cnt, 0);

    // Reset with two reads in flight.
    for (int a = 0; a < 4; a++) begin all_read(a); cycle(); end
    rst_ni = 1'b0;
    #1;
    chk("midrst_rdata", bank_rdata, '0);
    chk("midrst_init_done", init_done_o, 1'b0);
    chk("midrst_perr", parity_err_o, '0);
    model_reset();
    idle();
    repeat (2) cycle();
    rst_ni = 1'b1;
    repeat (DEPTH + 1) cycle();
    for (int a = 0; a < DEPTH; a++) begin all_read(a); cycle(); end
    idle();
    repeat (LAT + 1) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
